// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package sseg_pkg;

  // All segments dark, in active-low {g,f,e,d,c,b,a} form.
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Hex digit to segment table, active-low {g,f,e,d,c,b,a}; entry n at HEX_SEG[n].
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Turns a logical "this pin is on" into the pin level for the board polarity.
  function automatic logic apply_polarity(input logic active, input logic active_low);
    return active_low ? ~active : active;
  endfunction

endpackage

// File: rtl/sseg_hex_encoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sseg_hex_encoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver: prescaler, digit index,
// per-frame shadow capture, blanking at digit change, registered pin outputs.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_in,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic                          frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  // Pin levels meaning "off" for the selected polarity.
  localparam logic                  AL      = (ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_RST  = {NUM_DIGITS{AL}};
  localparam logic [6:0]            SEG_RST = AL ? SEG_OFF : ~SEG_OFF;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] dig_sh_q;
  logic [NUM_DIGITS-1:0]   dp_sh_q, blank_sh_q;
  logic                    frame_start;

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [IDX_W-1:0]        sel_q;
  logic                    tick_q, tick_d;

  logic [3:0]              nib_arr [NUM_DIGITS];
  logic [3:0]              cur_nib;
  logic [6:0]              enc_seg, seg_low;
  logic                    lit;

  // Prescaler and digit index next-state; the index wrap is explicit so any digit count works.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Capture happens only at frame start, which always lies inside a blanking interval.
  assign frame_start = enable && (cnt_q == '0) && (idx_q == '0);

  // Scan state and shadow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      dig_sh_q   <= '0;
      dp_sh_q    <= '0;
      blank_sh_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (frame_start) begin
        dig_sh_q   <= digits_in;
        dp_sh_q    <= dp_in;
        blank_sh_q <= blank_in;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib_arr[gi] = dig_sh_q[4*gi +: 4];
  end

  assign cur_nib = nib_arr[idx_q];

  sseg_hex_encoder u_enc (
    .nibble_i (cur_nib),
    .seg_o    (enc_seg)
  );

  // Current digit may be driven once past the blanking window and not masked.
  assign lit     = enable && (cnt_q >= BLANK_C) && !blank_sh_q[idx_q];
  assign seg_low = lit ? enc_seg : SEG_OFF;
  assign dp_d    = apply_polarity(lit && dp_sh_q[idx_q], AL);
  assign tick_d  = enable && (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
    assign an_d[gi] = apply_polarity(lit && (idx_q == IDX_W'(gi)), AL);
  end

  for (genvar gi = 0; gi < 7; gi++) begin : g_seg
    assign seg_d[gi] = apply_polarity(~seg_low[gi], AL);
  end

  // Registered pin outputs, one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q   <= AN_RST;
      seg_q  <= SEG_RST;
      dp_q   <= AL;
      sel_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      sel_q  <= idx_q;
      tick_q <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_sel  = sel_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver with 4 digits, 8-cycle slots, 2 blank cycles.
module tb_sseg_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  always #5 clk = ~clk;

  sseg_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  // Hex patterns, active-low {g,f,e,d,c,b,a}.
  logic [6:0] seg_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int g        = 0;   // model scan position (enabled edges since reset)

  logic [15:0] m_dig   = '0;
  logic [3:0]  m_dp    = '0;
  logic [3:0]  m_blank = '0;
  logic [3:0]  exp_an  = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp  = 1'b1;
  logic        exp_ft  = 1'b0;
  logic [1:0]  exp_sel = 2'd0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // Advance one clock edge, predicting the outputs from the state before the edge.
  task automatic step();
    int         slot;
    int         c;
    logic       lit;
    logic [3:0] oh;
    slot = (g / 8) % 4;
    c    = g % 8;
    lit  = enable && (c >= 2) && !m_blank[slot];
    oh   = 4'b0001 << slot;
    if (reset) begin
      g = 0; m_dig = '0; m_dp = '0; m_blank = '0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0; exp_sel = 2'd0;
    end else begin
      exp_an  = lit ? ~oh : 4'hF;
      exp_seg = lit ? seg_tbl[m_dig[slot*4 +: 4]] : 7'h7F;
      exp_dp  = lit ? ~m_dp[slot] : 1'b1;
      exp_ft  = enable && (g % 32 == 31);
      exp_sel = 2'(slot);
      if (enable) begin
        if (g % 32 == 0) begin
          m_dig = digits_in; m_dp = dp_in; m_blank = blank_in;
        end
        g++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_outputs();
    check_val("an", 32'(an), 32'(exp_an));
    check_val("seg", 32'(seg), 32'(exp_seg));
    check_val("dp", 32'(dp), 32'(exp_dp));
    check_val("frame_tick", 32'(frame_tick), 32'(exp_ft));
    check_val("digit_sel", 32'(digit_sel), 32'(exp_sel));
  endtask

  task automatic check_reset_vals();
    check_val("rst_an", 32'(an), 32'h0000_000F);
    check_val("rst_seg", 32'(seg), 32'h0000_007F);
    check_val("rst_dp", 32'(dp), 32'h1);
    check_val("rst_sel", 32'(digit_sel), 32'h0);
    check_val("rst_tick", 32'(frame_tick), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    cyc = 0;
    check_reset_vals();
  endtask

  initial begin
    // Basic scan of 1234, with a mid-frame input change to ABCD.
    digits_in = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000; enable = 1'b1;
    do_reset();
    repeat (40) begin
      step();
      if (cyc == 12) digits_in = 16'hABCD;
      check_outputs();
      if (cyc == 3)  begin check_val("s1_an_c3", 32'(an), 32'b1110); check_val("s1_seg_c3", 32'(seg), 32'b0011001); end
      if (cyc == 9)  check_val("s1_an_c9", 32'(an), 32'b1111);
      if (cyc == 11) begin check_val("s1_an_c11", 32'(an), 32'b1101); check_val("s1_seg_c11", 32'(seg), 32'b0110000); end
      if (cyc == 20) check_val("s1_seg_c20_old2", 32'(seg), 32'b0100100);
      if (cyc == 28) check_val("s1_seg_c28_old1", 32'(seg), 32'b1111001);
      if (cyc == 35) check_val("s1_seg_c35_d", 32'(seg), 32'b0100001);
    end

    // Blank mask on digit 2, decimal point on digit 0, three full frames.
    digits_in = 16'h1234; dp_in = 4'b0001; blank_in = 4'b0100; enable = 1'b1;
    do_reset();
    repeat (100) begin
      step();
      check_outputs();
      check_val("s2_an2_off", 32'(an[2]), 32'h1);
      if (cyc == 32 || cyc == 64 || cyc == 96) begin
        check_val("s2_tick", 32'(frame_tick), 32'h1);
        check_val("s2_sel_at_tick", 32'(digit_sel), 32'd3);
      end
      if (cyc == 33) check_val("s2_sel_after_tick", 32'(digit_sel), 32'd0);
      if (cyc == 5)  check_val("s2_dp_c5", 32'(dp), 32'h0);
      if (cyc == 12) check_val("s2_dp_c12", 32'(dp), 32'h1);
    end

    // Enable dropped for 5 cycles in the middle of digit 1.
    digits_in = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000; enable = 1'b1;
    do_reset();
    repeat (40) begin
      step();
      if (cyc == 14) enable = 1'b0;
      if (cyc == 19) enable = 1'b1;
      check_outputs();
      if (cyc >= 15 && cyc <= 19) check_val("s3_dark", 32'(an), 32'b1111);
      if (cyc == 21) check_val("s3_resume_an", 32'(an), 32'b1101);
      if (cyc == 22) check_val("s3_slot_end", 32'(an), 32'b1111);
      if (cyc == 32) check_val("s3_no_tick_32", 32'(frame_tick), 32'h0);
      if (cyc == 37) check_val("s3_tick_37", 32'(frame_tick), 32'h1);
    end

    // Reset asserted mid digit 2, then the scan restarts from digit 0.
    do_reset();
    repeat (20) begin
      step();
      check_outputs();
    end
    reset = 1'b1;
    step();
    check_reset_vals();
    reset = 1'b0;
    cyc = 0;
    repeat (12) begin
      step();
      check_outputs();
      if (cyc == 2)  check_val("s4_c2_dark", 32'(an), 32'b1111);
      if (cyc == 3)  begin check_val("s4_c3_an", 32'(an), 32'b1110); check_val("s4_c3_seg", 32'(seg), 32'b0011001); end
      if (cyc == 9)  check_val("s4_c9_dark", 32'(an), 32'b1111);
      if (cyc == 11) check_val("s4_c11_an", 32'(an), 32'b1101);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
